// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM and data memory: drains one store per free port cycle and
// probes buffered stores for loads. Define SB_FWD_EN to enable store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [7:0]  st_addr,
  input  logic [31:0] st_data,
  input  logic        st_by,
  input  logic        st_half,
  input  logic        ld_valid,
  input  logic [7:0]  ld_addr,
  input  logic        ld_by,
  input  logic        ld_half,
  input  logic        ld_unsign,
  output logic        ld_hit,
  output logic        ld_stall,
  output logic [31:0] ld_fwd_data,
  output logic        mem_we,
  output logic        mem_by,
  output logic        mem_half,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        by;
    logic        half;
  } sb_entry_t;

  function automatic logic [7:0] sz(input logic by, input logic half);
    return by ? 8'd1 : (half ? 8'd2 : 8'd4);
  endfunction

  sb_entry_t         ent [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic              full, push, drain_go;
  logic [DEPTH-1:0]  ov;
  logic              sel_found, fwd_ok;
  logic [PW-1:0]     sel_idx;
  logic [7:0]        lsz;
  sb_entry_t         head_e;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && st_ready;
  assign lsz      = sz(ld_by, ld_half);

  // Byte spans compared modulo 256 so stores near 0xFF wrap onto low addresses.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ov
    logic [7:0] esz;
    assign esz   = sz(ent[i].by, ent[i].half);
    assign ov[i] = ((ld_addr - ent[i].addr) < esz) || ((ent[i].addr - ld_addr) < lsz);
  end

  // Scan oldest to youngest; the last overlapping held entry (youngest) wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < count) && ov[head + PW'(k)]) begin
        sel_found = 1'b1;
        sel_idx   = head + PW'(k);
      end
    end
  end

`ifdef SB_FWD_EN
  sb_entry_t   sel_e;
  logic [31:0] ext;
  assign sel_e  = ent[sel_idx];
  assign fwd_ok = sel_found && (sel_e.addr == ld_addr) && (sz(sel_e.by, sel_e.half) >= lsz);

  always_comb begin
    ext = sel_e.data;
    if (ld_by)
      ext = ld_unsign ? {24'b0, sel_e.data[7:0]} : {{24{sel_e.data[7]}}, sel_e.data[7:0]};
    else if (ld_half)
      ext = ld_unsign ? {16'b0, sel_e.data[15:0]} : {{16{sel_e.data[15]}}, sel_e.data[15:0]};
  end

  assign ld_fwd_data = ld_hit ? ext : 32'b0;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{ld_unsign, sel_idx};
  assign fwd_ok      = 1'b0;
  assign ld_fwd_data = 32'b0;
`endif

  assign ld_hit   = ld_valid && fwd_ok;
  assign ld_stall = ld_valid && sel_found && !fwd_ok;

  // Only a plain missing load takes the memory port; reset suppresses any write.
  assign drain_go = !rst && !empty && !(ld_valid && !ld_hit && !ld_stall);
  assign head_e   = ent[head];
  assign mem_we    = drain_go;
  assign mem_addr  = empty ? 8'b0  : head_e.addr;
  assign mem_wdata = empty ? 32'b0 : head_e.data;
  assign mem_by    = !empty && head_e.by;
  assign mem_half  = !empty && head_e.half;

  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{addr: st_addr, data: st_data, by: st_by, half: st_half};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)     tail <= tail + PW'(1);
      if (drain_go) head <= head + PW'(1);
      case ({push, drain_go})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations follow SB_FWD_EN when defined.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [7:0]  st_addr;
  logic [31:0] st_data;
  logic        st_by, st_half;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic        ld_by, ld_half, ld_unsign;
  logic        ld_hit, ld_stall;
  logic [31:0] ld_fwd_data;
  logic        mem_we, mem_by, mem_half;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_by(st_by), .st_half(st_half),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_by(ld_by), .ld_half(ld_half),
    .ld_unsign(ld_unsign), .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_fwd_data(ld_fwd_data),
    .mem_we(mem_we), .mem_by(mem_by), .mem_half(mem_half), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d, input logic b, input logic h);
    st_valid = 1'b1; st_addr = a; st_data = d; st_by = b; st_half = h;
    step();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic b, input logic h, input logic u);
    ld_valid = 1'b1; ld_addr = a; ld_by = b; ld_half = h; ld_unsign = u;
  endtask

  // A missing word load keeps the memory port busy so stores stay buffered.
  task automatic hold();
    load(8'h80, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_by = 1'b0; st_half = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_by = 1'b0; ld_half = 1'b0; ld_unsign = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_fwd", ld_fwd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_size", {mem_by, mem_half}, 0);

    // single store drains next cycle
    push(8'h10, 32'h11223344, 1'b0, 1'b0);
    chk("s1_mem_we", mem_we, 1);
    chk("s1_mem_addr", mem_addr, 32'h10);
    chk("s1_mem_wdata", mem_wdata, 32'h11223344);
    step();
    chk("s1_empty", empty, 1);
    chk("s1_mem_we_off", mem_we, 0);

    // fill behind a missing load, extra push while full is dropped
    hold();
    for (int i = 0; i < 4; i++) begin
      push(8'h40 + 8'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      chk($sformatf("s2_blocked_%0d", i), mem_we, 0);
    end
    chk("s2_full_ready", st_ready, 0);
    push(8'h50, 32'hDEAD, 1'b0, 1'b0);
    chk("s2_full_we", mem_we, 0);
    ld_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_we_%0d", i), mem_we, 1);
      chk($sformatf("s2_addr_%0d", i), mem_addr, 32'h40 + 32'(4 * i));
      chk($sformatf("s2_data_%0d", i), mem_wdata, 32'hA0 + 32'(i));
      step();
    end
    chk("s2_empty", empty, 1);
    chk("s2_we_done", mem_we, 0);

    // forwarding / extension from a buffered word
    hold();
    push(8'h20, 32'h000080FF, 1'b0, 1'b0);
    load(8'h20, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef SB_FWD_EN
    chk("s3_b_hit", ld_hit, 1);
    chk("s3_b_stall", ld_stall, 0);
    chk("s3_b_data", ld_fwd_data, 32'hFFFFFFFF);
`else
    chk("s3_b_hit", ld_hit, 0);
    chk("s3_b_stall", ld_stall, 1);
    chk("s3_b_data", ld_fwd_data, 0);
`endif
    chk("s3_b_we", mem_we, 1);
    load(8'h20, 1'b0, 1'b1, 1'b1);
    #1;
`ifdef SB_FWD_EN
    chk("s3_hu_data", ld_fwd_data, 32'h000080FF);
`else
    chk("s3_hu_stall", ld_stall, 1);
`endif
    load(8'h20, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef SB_FWD_EN
    chk("s3_hs_data", ld_fwd_data, 32'hFFFF80FF);
`else
    chk("s3_hs_hit", ld_hit, 0);
`endif
    step();
    chk("s3_after_hit", ld_hit, 0);
    chk("s3_after_stall", ld_stall, 0);
    chk("s3_after_empty", empty, 1);

    // partial overlap stalls but does not block the drain
    hold();
    push(8'h21, 32'h000000AA, 1'b1, 1'b0);
    load(8'h20, 1'b0, 1'b0, 1'b0);
    #1;
    chk("s4_stall", ld_stall, 1);
    chk("s4_hit", ld_hit, 0);
    chk("s4_we", mem_we, 1);
    chk("s4_by", mem_by, 1);
    step();
    chk("s4_stall_clr", ld_stall, 0);
    chk("s4_hit_clr", ld_hit, 0);

    // youngest wins, address wrap
    hold();
    push(8'h30, 32'h1, 1'b0, 1'b0);
    push(8'h30, 32'h2, 1'b0, 1'b0);
    load(8'h30, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef SB_FWD_EN
    chk("s5_young_hit", ld_hit, 1);
    chk("s5_young_data", ld_fwd_data, 32'h2);
`else
    chk("s5_young_stall", ld_stall, 1);
    chk("s5_young_data", ld_fwd_data, 0);
`endif
    hold();
    #1;
    push(8'hFE, 32'h3, 1'b0, 1'b0);
    load(8'h01, 1'b1, 1'b0, 1'b0);
    #1;
    chk("s5_wrap_stall", ld_stall, 1);
    chk("s5_wrap_hit", ld_hit, 0);
    load(8'h02, 1'b1, 1'b0, 1'b0);
    #1;
    chk("s5_nowrap_stall", ld_stall, 0);
    chk("s5_nowrap_we", mem_we, 0);

    // full buffer discarded by reset
    push(8'h60, 32'h4, 1'b0, 1'b0);
    chk("s6_full", st_ready, 0);
    rst = 1'b1; ld_valid = 1'b0;
    #1;
    chk("s6_rst_we", mem_we, 0);
    step();
    rst = 1'b0;
    #1;
    chk("s6_empty", empty, 1);
    chk("s6_ready", st_ready, 1);
    chk("s6_we", mem_we, 0);
    chk("s6_addr", mem_addr, 0);
    step();
    chk("s6_we_later", mem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the MEM stage and the byte-addressed data memory. Stores from the pipeline are queued in a small in-order FIFO and drained one per cycle into the memory write port whenever no load is using that port. Loads probe the buffer every cycle: a covering store forwards its data, a partially overlapping store stalls the load, and a miss goes straight to memory. The memory-side outputs map one-to-one onto the data memory's MemWrite/by/half/addr/data_in inputs.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept a store; equals !full
- st_addr  in  8  store byte address
- st_data  in  32  store data, little-endian, low bytes used for byte/half
- st_by, st_half  in  1  store size: byte, halfword; both low = word
- ld_valid  in  1  load probe from MEM stage
- ld_addr  in  8  load byte address
- ld_by, ld_half, ld_unsign  in  1  load size and zero-extend select
- ld_hit  out  1  load fully served by forwarding
- ld_stall  out  1  load overlaps a buffered store it cannot forward from
- ld_fwd_data  out  32  forwarded, extended load data; 0 when !ld_hit
- mem_we  out  1  drain write strobe (to MemWrite)
- mem_by, mem_half  out  1  size of draining entry
- mem_addr  out  8  address of draining entry
- mem_wdata  out  32  data of draining entry
- empty  out  1  no entries held (fence / halt condition)

## Operation
- Entry = {addr, data, by, half}; circular FIFO with head, tail pointers and count (width clog2(DEPTH)+1).
- Push: st_valid & st_ready writes entry at tail, tail advances (wraps at DEPTH).
- Store accepted only when st_ready; st_valid with full is ignored — upstream holds the request.
- Byte span of an entry/load: addr .. addr+size-1, size 1/2/4, computed modulo 256.
- Load probe is combinational over entries held at the start of the cycle; a store pushed in the same cycle is not visible.
- Overlap search runs youngest to oldest; first overlapping entry decides:
  - same addr and store size >= load size → ld_hit=1, data taken from low bytes of that entry, extended as memory does: byte/half sign-extend unless ld_unsign, word unchanged.
  - any other overlap → ld_stall=1, ld_hit=0.
  - no overlap → both 0.
- Drain: drain_go = !empty & !(ld_valid & !ld_hit & !ld_stall). A plain missing load owns the memory port that cycle; a stalled load never blocks the drain.
- When drain_go: mem_we=1, mem_* driven from head entry; head advances at clock edge.
- When !drain_go: mem_we=0, mem_* hold head entry contents (don't-care to memory).
- Push and drain in the same cycle: count unchanged.
- Ordering: entries drain strictly in push order.

## Timing
- Reset: head=tail=count=0; st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_stall=0, ld_fwd_data=0, mem_addr=0, mem_wdata=0, mem_by=mem_half=0. Entry storage not cleared.
- Store accepted in cycle N is eligible to drain in cycle N+1 at earliest and forwards to loads from cycle N+1.
- Drain throughput one entry per cycle; memory latches write at the edge ending the mem_we cycle.
- st_ready and empty depend only on registered count; no combinational path from mem side.
- ld_hit, ld_stall, ld_fwd_data are combinational from ld_* and registered entries.
- rst asserted mid-drain or while full: all buffered stores are discarded at that edge; no write issued in the reset cycle.

## Configuration
- SB_FWD_EN defined: forwarding as above.
- SB_FWD_EN undefined: no forwarding logic; any overlap → ld_stall=1; ld_hit and ld_fwd_data tied 0.

## Test plan
- Reset, then push word 0x11223344 @0x10, no loads → next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x11223344, then empty=1.
- Push 4 stores with ld_valid held as a missing load @0x80 → st_ready=0 after fourth, mem_we=0 throughout; release load → drains 4 cycles in push order.
- Buffer word 0x000080FF @0x20; load byte signed @0x20 → ld_hit=1, ld_fwd_data=0xFFFFFFFF; unsigned half → 0x000080FF.
- Buffer byte 0xAA @0x21; load word @0x20 → ld_stall=1, mem_we=1 same cycle; next cycle ld_stall=0, ld_hit=0.
- Two words @0x30 (0x1, then 0x2); load word @0x30 → ld_fwd_data=0x2 (youngest wins); word store @0xFE overlaps byte load @0x01 → ld_stall=1 (wrap).
- Full buffer, rst pulse → empty=1, st_ready=1, no mem_we afterwards; with SB_FWD_EN undefined, scenario 3 gives ld_stall=1, ld_hit=0.
